local_pattern_table: RTL and testbench

Second stage of the tournament local predictor. Consumes the 10-bit local history produced each cycle by the local history table and indexes a table of saturating counters to produce a taken/not-taken prediction. Each accepted lookup is recorded in an in-order outstanding-prediction queue. When the branch resolves, the oldest entry is popped, its counter is trained, and a registered mispredict pulse is returned to the tournament chooser.

---
 rtl/local_pattern_table.sv | 113 +++++++++++
 tb/tb_local_pattern_table.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/local_pattern_table.sv
// Local pattern table: saturating-counter predictor indexed by local history,
// with an in-order queue of outstanding predictions trained on resolve.
module local_pattern_table #(
    parameter int HIST_BITS   = 10,
    parameter int CTR_BITS    = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 lookup_valid,
    input  logic [HIST_BITS-1:0]                 lookup_hist,
    output logic                                 lookup_ready,
    output logic                                 predict_taken,
    output logic [CTR_BITS-1:0]                  predict_conf,
    input  logic                                 resolve_valid,
    input  logic                                 resolve_taken,
    output logic                                 resolve_ready,
    output logic                                 resolve_mispredict,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]     pending_count,
    input  logic                                 flush
);
    localparam int ENTRIES = 1 << HIST_BITS;
    localparam int PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W   = $clog2(QUEUE_DEPTH+1);

    localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(QUEUE_DEPTH-1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;
    // weakly not-taken: just below the taken threshold
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS-1)) - 1);

    logic [CTR_BITS-1:0]  ctr    [ENTRIES];
    logic [HIST_BITS-1:0] q_hist [QUEUE_DEPTH];
    logic                 q_pred [QUEUE_DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             mispredict;

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [HIST_BITS-1:0] head_hist;
    logic [CTR_BITS-1:0]  head_ctr;
    logic [CTR_BITS-1:0]  trained_ctr;
    logic [PTR_W-1:0]     head_next;
    logic [PTR_W-1:0]     tail_next;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = lookup_valid && !full && !flush;
    assign pop   = resolve_valid && !empty && !flush;

    assign head_hist = q_hist[head];
    assign head_ctr  = ctr[head_hist];
    assign head_next = (head == LAST_PTR) ? '0 : head + PTR_W'(1);
    assign tail_next = (tail == LAST_PTR) ? '0 : tail + PTR_W'(1);

    always_comb begin
        trained_ctr = head_ctr;
        if (resolve_taken) begin
            if (head_ctr != CTR_MAX) trained_ctr = head_ctr + CTR_BITS'(1);
        end else begin
            if (head_ctr != CTR_MIN) trained_ctr = head_ctr - CTR_BITS'(1);
        end
    end

    assign predict_conf       = ctr[lookup_hist];
    assign predict_taken      = predict_conf[CTR_BITS-1];
    assign lookup_ready       = !full;
    assign resolve_ready      = !empty;
    assign resolve_mispredict = mispredict;
    assign pending_count      = count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
        end else if (pop) begin
            ctr[head_hist] <= trained_ctr;
        end
    end

    // queue payload needs no reset; head/tail/count define validity
    always_ff @(posedge clock) begin
        if (push) begin
            q_hist[tail] <= lookup_hist;
            q_pred[tail] <= predict_taken;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            mispredict <= 1'b0;
        end else if (flush) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            mispredict <= 1'b0;
        end else begin
            mispredict <= pop && (q_pred[head] != resolve_taken);
            if (push) tail <= tail_next;
            if (pop)  head <= head_next;
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_local_pattern_table.sv
// Randomized scoreboard bench for local_pattern_table against a queue/array model.
module tb_local_pattern_table;
    logic       clock = 0;
    logic       reset;
    logic       lookup_valid;
    logic [9:0] lookup_hist;
    logic       lookup_ready;
    logic       predict_taken;
    logic [1:0] predict_conf;
    logic       resolve_valid;
    logic       resolve_taken;
    logic       resolve_ready;
    logic       resolve_mispredict;
    logic [2:0] pending_count;
    logic       flush;

    local_pattern_table dut (
        .clock(clock), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_hist(lookup_hist),
        .lookup_ready(lookup_ready), .predict_taken(predict_taken),
        .predict_conf(predict_conf), .resolve_valid(resolve_valid),
        .resolve_taken(resolve_taken), .resolve_ready(resolve_ready),
        .resolve_mispredict(resolve_mispredict),
        .pending_count(pending_count), .flush(flush)
    );

    always #5 clock = ~clock;

    typedef struct { int mis; int taken; int conf; int pend; int lrdy; int rrdy; } exp_t;
    typedef struct { int hist; int pred; } ent_t;

    exp_t exp_q[$];
    ent_t mq[$];
    int   mctr[1024];
    int   mmis;
    int   checks = 0;
    int   passed = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mispredict", resolve_mispredict, e.mis);
            chk("predict_taken", predict_taken, e.taken);
            chk("predict_conf", predict_conf, e.conf);
            chk("pending_count", pending_count, e.pend);
            chk("lookup_ready", lookup_ready, e.lrdy);
            chk("resolve_ready", resolve_ready, e.rrdy);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) mctr[i] = 1;
        mq.delete();
        mmis = 0;
    endtask

    task automatic cyc(input int lv, input int lh, input int rv, input int rt, input int fl);
        exp_t e;
        int   pred;
        ent_t h;
        @(posedge clock);
        #1;
        lookup_valid  = lv[0];
        lookup_hist   = lh[9:0];
        resolve_valid = rv[0];
        resolve_taken = rt[0];
        flush         = fl[0];
        pred   = (mctr[lh] >= 2) ? 1 : 0;
        e.mis  = mmis;
        e.taken = pred;
        e.conf = mctr[lh];
        e.pend = mq.size();
        e.lrdy = (mq.size() < 4) ? 1 : 0;
        e.rrdy = (mq.size() > 0) ? 1 : 0;
        exp_q.push_back(e);
        if (fl != 0) begin
            mq.delete();
            mmis = 0;
        end else begin
            int do_push;
            do_push = (lv != 0 && mq.size() < 4) ? 1 : 0;
            mmis = 0;
            if (rv != 0 && mq.size() > 0) begin
                h = mq.pop_front();
                mmis = (h.pred != rt) ? 1 : 0;
                if (rt != 0) mctr[h.hist] = (mctr[h.hist] < 3) ? mctr[h.hist] + 1 : 3;
                else         mctr[h.hist] = (mctr[h.hist] > 0) ? mctr[h.hist] - 1 : 0;
            end
            if (do_push != 0) begin
                h.hist = lh;
                h.pred = pred;
                mq.push_back(h);
            end
        end
    endtask

    initial begin
        reset = 1;
        lookup_valid = 0; lookup_hist = 0;
        resolve_valid = 0; resolve_taken = 0; flush = 0;
        model_reset();
        #12;
        reset = 0;

        // reset state
        cyc(0, 'h3FF, 0, 0, 0);
        // first training flips weak not-taken into weak taken
        cyc(1, 'h155, 0, 0, 0);
        cyc(0, 'h155, 1, 1, 0);
        cyc(0, 'h155, 0, 0, 0);
        cyc(1, 'h155, 0, 0, 0);
        cyc(0, 'h155, 1, 1, 0);
        cyc(0, 'h155, 0, 0, 0);
        // saturation both ways
        for (int i = 0; i < 5; i++) begin
            cyc(1, 'h0AA, 0, 0, 0);
            cyc(0, 'h0AA, 1, 1, 0);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1, 'h0AA, 0, 0, 0);
            cyc(0, 'h0AA, 1, 0, 0);
        end
        cyc(0, 'h0AA, 0, 0, 0);
        // ordering
        cyc(1, 1, 0, 0, 0);
        cyc(1, 2, 0, 0, 0);
        cyc(1, 3, 0, 0, 0);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 2, 1, 0, 0);
        cyc(0, 3, 1, 1, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 2, 0, 0, 0);
        // full, push ignored during pop, empty resolve ignored
        for (int i = 0; i < 4; i++) cyc(1, 16 + i, 0, 0, 0);
        cyc(1, 30, 1, 1, 0);
        cyc(0, 30, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 17 + i, 1, 0, 0);
        cyc(0, 16, 1, 1, 0);
        cyc(0, 16, 0, 0, 0);
        // flush priority
        for (int i = 0; i < 3; i++) cyc(1, 40 + i, 0, 0, 0);
        cyc(1, 40, 1, 1, 1);
        cyc(0, 40, 0, 0, 0);
        cyc(0, 41, 1, 1, 0);
        // random traffic over a small index set to force aliasing
        for (int i = 0; i < 400; i++) begin
            int lv, rv, rt, fl, lh;
            lv = ($urandom_range(0, 99) < 60) ? 1 : 0;
            rv = ($urandom_range(0, 99) < 50) ? 1 : 0;
            rt = $urandom_range(0, 1);
            fl = ($urandom_range(0, 99) < 3) ? 1 : 0;
            lh = $urandom_range(0, 7);
            cyc(lv, lh, rv, rt, fl);
        end
        // leave a mispredict pulse and outstanding entries, then reset mid-cycle
        cyc(1, 'h155, 0, 0, 0);
        cyc(1, 5, 0, 0, 0);
        cyc(1, 6, 1, 0, 0);
        @(posedge clock);
        #1;
        lookup_valid = 0; resolve_valid = 0; flush = 0;
        lookup_hist = 10'h155;
        #2;
        reset = 1;
        #1;
        chk("rst_conf", predict_conf, 1);
        chk("rst_taken", predict_taken, 0);
        chk("rst_pending", pending_count, 0);
        chk("rst_lready", lookup_ready, 1);
        chk("rst_rready", resolve_ready, 0);
        chk("rst_mis", resolve_mispredict, 0);
        @(posedge clock);
        #3;
        reset = 0;
        model_reset();
        cyc(0, 'h155, 0, 0, 0);
        cyc(1, 'h0AA, 0, 0, 0);
        cyc(0, 'h0AA, 1, 0, 0);
        cyc(0, 'h0AA, 0, 0, 0);
        repeat (2) @(posedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
